// File: rtl/prg_load_ctrl.sv
// rtl/prg_load_ctrl.sv - PRG/cart download to SDRAM write sequencer
// Buffers payload bytes, then writes the BASIC end-pointer block and optionally pulses reset.
module prg_load_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] CART_ADDR  = 16'hA000,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic [7:0]  dl_index,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        hdr_mode,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        busy,
  output logic        force_reset,
  output logic        overflow
);
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, INJECT, RSTP} state_t;
  state_t state_q, state_d;

  logic [15:0]    fifo_addr_q [FIFO_DEPTH];
  logic [7:0]     fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    pointer_q, pointer_d;
  logic           hdr_valid_q, hdr_valid_d, hdr_parse_q, hdr_parse_d;
  logic           auto_reset_q, auto_reset_d, overflow_q, overflow_d;
  logic           armed_q, armed_d;
  logic [2:0]     inj_idx_q, inj_idx_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           fifo_empty, fifo_full, payload, push, pop, hdr_byte;
  logic [15:0]    inj_addr;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    hdr_byte   = hdr_parse_q && (dl_addr == 16'd0 || dl_addr == 16'd1);
    payload    = (state_q == LOAD) && dl_wr && !hdr_byte;
    pop        = mem_ack && !fifo_empty && (state_q == LOAD || state_q == DRAIN);
    push       = payload && (!fifo_full || pop);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pointer_q    <= '0;
      hdr_valid_q  <= 1'b0;
      hdr_parse_q  <= 1'b0;
      auto_reset_q <= 1'b0;
      overflow_q   <= 1'b0;
      armed_q      <= 1'b0;
      inj_idx_q    <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pointer_q    <= pointer_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_parse_q  <= hdr_parse_d;
      auto_reset_q <= auto_reset_d;
      overflow_q   <= overflow_d;
      armed_q      <= armed_d;
      inj_idx_q    <= inj_idx_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= pointer_q;
      fifo_data_q[wr_ptr_q] <= dl_data;
    end
  end

  // A download only starts once dl_active has been seen low since reset.
  always_comb begin
    state_d      = state_q;
    pointer_d    = pointer_q;
    hdr_valid_d  = hdr_valid_q;
    hdr_parse_d  = hdr_parse_q;
    auto_reset_d = auto_reset_q;
    overflow_d   = overflow_q;
    inj_idx_d    = inj_idx_q;
    rst_cnt_d    = rst_cnt_q;
    armed_d      = armed_q | ~dl_active;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    if (dl_wr && state_q != LOAD) overflow_d = 1'b1;
    if (payload && !push) overflow_d = 1'b1;
    if (push && pointer_q == CART_ADDR) auto_reset_d = 1'b1;
    if (payload) pointer_d = pointer_q + 16'd1;
    if (state_q == LOAD && dl_wr && hdr_parse_q && dl_addr == 16'd0) pointer_d[7:0] = dl_data;
    if (state_q == LOAD && dl_wr && hdr_parse_q && dl_addr == 16'd1) begin
      pointer_d[15:8] = dl_data;
      hdr_valid_d     = 1'b1;
    end

    case (state_q)
      IDLE: if (dl_active && armed_q && dl_index != 8'd0) begin
        state_d      = LOAD;
        hdr_parse_d  = hdr_mode || (dl_index[4:0] == 5'd1);
        pointer_d    = hdr_parse_d ? 16'd0 : CART_ADDR;
        hdr_valid_d  = !hdr_parse_d;
        auto_reset_d = 1'b0;
        overflow_d   = dl_wr;
      end
      LOAD: if (!dl_active) state_d = DRAIN;
      DRAIN: begin
        inj_idx_d = '0;
        if (fifo_empty) state_d = hdr_valid_q ? INJECT : IDLE;
      end
      INJECT: if (mem_ack) begin
        inj_idx_d = inj_idx_q + 3'd1;
        rst_cnt_d = '0;
        if (inj_idx_q == 3'd7) state_d = auto_reset_q ? RSTP : IDLE;
      end
      RSTP: begin
        rst_cnt_d = rst_cnt_q + RCW'(1);
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d      = IDLE;
          auto_reset_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (inj_idx_q)
      3'd0:    inj_addr = 16'h002D;
      3'd1:    inj_addr = 16'h002E;
      3'd2:    inj_addr = 16'h002F;
      3'd3:    inj_addr = 16'h0030;
      3'd4:    inj_addr = 16'h0031;
      3'd5:    inj_addr = 16'h0032;
      3'd6:    inj_addr = 16'h00AE;
      default: inj_addr = 16'h00AF;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = 16'd0;
    mem_data    = 8'd0;
    busy        = (state_q != IDLE);
    force_reset = (state_q == RSTP);
    overflow    = overflow_q;
    case (state_q)
      LOAD, DRAIN: if (!fifo_empty) begin
        mem_req  = 1'b1;
        mem_addr = fifo_addr_q[rd_ptr_q];
        mem_data = fifo_data_q[rd_ptr_q];
      end
      INJECT: begin
        mem_req  = 1'b1;
        mem_addr = inj_addr;
        mem_data = inj_idx_q[0] ? pointer_q[15:8] : pointer_q[7:0];
      end
      default: ;
    endcase
  end
endmodule

// File: doc/prg_load_ctrl.md
PRG_LOAD_CTRL -- requirements
Module: prg_load_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, payload byte buffer entries (power of 2, >=2).
REQ-002 Parameter CART_ADDR, 16'hA000, raw-load base and auto-reset trigger address.
REQ-003 Parameter RST_CYCLES, 16, force_reset pulse length in clk_sys cycles.
REQ-004 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 dl_active  in  1  PRG/cart download in progress.
REQ-007 dl_index  in  8  download type; 0 = ROM (ignored by this block).
REQ-008 dl_wr  in  1  one-cycle byte strobe.
REQ-009 dl_addr  in  16  byte offset within file.
REQ-010 dl_data  in  8  file byte.
REQ-011 hdr_mode  in  1  1 = first two bytes are little-endian load address; 0 = raw load to CART_ADDR.
REQ-012 mem_req  out  1  SDRAM write request; held until mem_ack.
REQ-013 mem_addr  out  16  write address.
REQ-014 mem_data  out  8  write data.
REQ-015 mem_ack  in  1  one-cycle write-complete pulse; valid only while mem_req high.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 force_reset  out  1  machine reset request pulse.
REQ-018 overflow  out  1  sticky dropped-byte flag.

Function
REQ-019 States: IDLE, LOAD, DRAIN, INJECT, RSTP; start in IDLE.
REQ-020 IDLE -> LOAD on dl_active high with dl_index != 0; clears pointer, header-valid, auto_reset and overflow.
REQ-021 Header parsing applies when hdr_mode=1 or dl_index[4:0]==1: dl_addr 0 loads pointer[7:0], dl_addr 1 loads pointer[15:8] and sets header-valid; no writes for these bytes.
REQ-022 Raw mode: pointer := CART_ADDR on entry to LOAD, header-valid set immediately.
REQ-023 Each payload byte: push {pointer, dl_data} into FIFO, then pointer := pointer+1, modulo 2^16 ($FFFF wraps to $0000).
REQ-024 Payload byte pushed with address == CART_ADDR sets auto_reset.
REQ-025 mem_req = FIFO non-empty (LOAD/DRAIN) or pending inject write (INJECT); mem_addr/mem_data = FIFO head or inject entry, stable while mem_req high.
REQ-026 mem_ack pops head in the same cycle; push and pop in one cycle both take effect, including when full.
REQ-027 Push when full without simultaneous pop: byte dropped, overflow set; pointer still increments.
REQ-028 dl_wr in any state other than LOAD: ignored, overflow set.
REQ-029 LOAD -> DRAIN when dl_active low; DRAIN -> INJECT when FIFO empty and header-valid; DRAIN -> IDLE when FIFO empty and header-valid clear.
REQ-030 INJECT issues 8 sequential writes of end pointer E (final pointer value): $2D=E[7:0], $2E=E[15:8], $2F=E[7:0], $30=E[15:8], $31=E[7:0], $32=E[15:8], $AE=E[7:0], $AF=E[15:8]; each awaits mem_ack, next request at earliest the following cycle.
REQ-031 After 8th ack: -> RSTP if auto_reset, else IDLE.
REQ-032 RSTP: force_reset high exactly RST_CYCLES cycles, then IDLE; auto_reset cleared.
REQ-033 dl_index==0 downloads: remain IDLE, no mem_req.
REQ-034 mem_ack when mem_req low: ignored.

Reset
REQ-035 reset asserted: state IDLE, FIFO empty, pointer 0, mem_req/busy/force_reset/overflow 0, mem_addr/mem_data 0, immediately (asynchronous).
REQ-036 reset mid-LOAD/INJECT/RSTP aborts operation; no further mem_req until a new dl_active rising in IDLE after reset release.

Verification
REQ-037 hdr_mode=1, bytes 01,10,AA,BB,CC, mem_ack 1 cycle after each req -> writes $1001=AA,$1002=BB,$1003=CC, then 8 injects E=$1004 ($2D=04,$2E=10...$AF=10), no force_reset.
REQ-038 hdr_mode=0, dl_index=2, 3 bytes -> writes $A000..$A002, E=$A003, force_reset high exactly 16 cycles.
REQ-039 mem_ack withheld, 6 payload strobes with FIFO_DEPTH=4 -> first 4 retained, overflow=1, pointer advanced by 6.
REQ-040 Header FF,FF then 2 bytes -> writes $FFFF then $0000, E=$0001.
REQ-041 File of 1 byte (header incomplete) -> no mem_req, busy falls after dl_active drops.
REQ-042 reset pulse during INJECT write 3 -> mem_req low same cycle, state IDLE, no further writes.
